data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port 256x8 data memory.
- Port 0 serves the core load/store path; port 1 serves a secondary master (test loader / DMA).
- Each accepted request is latched, then driven onto the memory for exactly one access cycle. Read data is captured into a per-port register and returned with a valid pulse.
- The memory's own read/write enables are driven only during that access cycle, so the memory performs no access while the arbiter is idle.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins a tie.
- AW, 8: address width (memory depth 2^AW).
- DW, 8: data width.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until gnt0.
- we0  in  1  port 0 access type: 1 = write, 0 = read.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 request accepted (1-cycle pulse).
- rvalid0  out  1  port 0 read data valid (1-cycle pulse).
- rdata0  out  DW  port 0 read data; holds until the next port 0 read.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_addr  out  AW  memory address.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; combinational from mem_addr, undriven (Z) when mem_read=0.
- busy  out  1  high in ACCESS state.

Behaviour:
- Reset values (applied asynchronously):
  - state = IDLE; last_winner = 1, so port 0 wins the first tie.
  - gnt*, rvalid*, mem_read, mem_write, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
- FSM, two states:
  - IDLE: if no req, stay. Otherwise select a winner:
    - single requester wins;
    - on a tie: FIXED_PRIO=1 gives port 0; FIXED_PRIO=0 gives the port != last_winner.
    - Combinationally pulse gnt of the winner only.
    - On the clock edge: latch addr, wdata, we and winner id into internal regs; update last_winner; go to ACCESS.
  - ACCESS (always exactly 1 cycle):
    - mem_addr/mem_wdata driven from the latched regs.
    - mem_write = latched we; mem_read = !latched we. Both decoded from state, never asserted in IDLE.
    - On the ending edge: a write commits in memory; for a read, mem_rdata is registered into rdata of the winning port and rvalid of that port is set for the following cycle.
    - Next state = IDLE.
- Latency and throughput:
  - Read: gnt in cycle N, memory access in N+1, rvalid and rdata in N+2.
  - Write: gnt in cycle N, commit at the end of N+1; no response pulse.
  - Peak rate: one access per 2 cycles. The IDLE cycle carrying rvalid may also accept a new request (gnt and rvalid may coincide).
- Handshake rules:
  - A requester samples gnt in the same cycle it drives req. After gnt it may change or drop req/addr/wdata.
  - A req held after gnt counts as a new request at the next IDLE.
  - A req dropped before gnt is never serviced.
- Output hold behaviour:
  - mem_addr/mem_wdata keep their last latched value in IDLE.
  - rdata of the non-winning port is unchanged.
  - Writes never modify rdata.
- Starvation: with FIXED_PRIO=0 and both ports requesting continuously, grants strictly alternate 0,1,0,1,...
- Reset mid-ACCESS: mem_write/mem_read drop immediately (asynchronous), so no write commits on the next edge. Latched request is discarded; no rvalid.
- mem_rdata is sampled only in ACCESS with mem_read=1; a Z/X value at any other time has no effect.
- Widths: all address/data paths pass through unmodified, with no arithmetic.

Test Plan:
- Reset then idle: Reset pulse mid-cycle → all outputs 0 immediately; no mem_read/mem_write for 10 cycles with req0=req1=0.
- Single write then read: port 0 writes addr 0x3C = 0xA5 (gnt0 in cycle 1, mem_write=1 in cycle 2 only). Port 0 then reads 0x3C → rvalid0 pulse two cycles after gnt0 with rdata0=0xA5; rdata1 unchanged.
- Round-robin, FIXED_PRIO=0: req0 and req1 held high for 8 grants → grant order 0,1,0,1,0,1,0,1; gnt always one-hot; port 1 reads 0x10 (preloaded 0x77) → rdata1=0x77.
- Fixed priority, FIXED_PRIO=1: both ports held high → port 0 granted every IDLE; port 1 granted in the first IDLE after req0 drops.
- Back-to-back: port 1 reads 0xFF, then immediately reads 0x00 → the second gnt1 coincides with the first rvalid1. Data is correct for both; boundary addresses 0x00/0xFF accessed without wrap error.
- Reset during ACCESS of a write to 0x55 (old value 0x11): assert Reset in the ACCESS cycle → memory still reads 0x11 after reset; no rvalid; first request afterwards goes to port 0 on a tie.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port arbiter/sequencer in front of a single-port data memory.
//   Port 0 serves the core load/store path, port 1 a secondary master
//   (test loader / DMA). An accepted request is latched in IDLE and driven
//   onto the memory for exactly one ACCESS cycle. Read data is captured
//   into a per-port register and returned with a one-cycle valid pulse.
//
// Parameters
//   FIXED_PRIO  0 = round-robin on a tie, 1 = port 0 always wins a tie
//   AW          address width (memory depth 2^AW)
//   DW          data width
//
// Ports
//   CLK, Reset                       clock (rising edge), async active-high reset
//   req*, we*, addr*, wdata*         per-port request (held until gnt*)
//   gnt*                             per-port accept pulse (combinational, IDLE only)
//   rvalid*, rdata*                  per-port read response; rdata* holds between reads
//   mem_addr, mem_wdata              memory address / write data (hold last latched value)
//   mem_read, mem_write              memory enables, asserted only in ACCESS
//   mem_rdata                        memory read data, may be Z outside a read
//   busy                             high in ACCESS
module data_mem_arbiter #(
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned AW         = 8,
   parameter int unsigned DW         = 8
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_read,
   output logic          mem_write,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic {StIdle, StAccess} stateT;

   stateT         stateQ, stateD;
   logic          lastWinnerQ;
   logic          winnerQ;
   logic          weQ;
   logic [AW-1:0] addrQ;
   logic [DW-1:0] wdataQ;
   logic [DW-1:0] rdata0Q, rdata1Q;
   logic          rvalid0Q, rvalid1Q;
   logic          anyReq;
   logic          winner;
   logic          accept;

   assign anyReq = req0 | req1;
   assign accept = (stateQ == StIdle) && anyReq;

   // Winner selection; on a tie round-robin favours the port that did not win last.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = (FIXED_PRIO != 0) ? 1'b0 : ~lastWinnerQ;
      end else begin
         winner = req1;
      end
   end

   always_comb begin
      stateD = stateQ;
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      case (stateQ)
         StIdle: begin
            if (anyReq) begin
               gnt0   = ~winner;
               gnt1   = winner;
               stateD = StAccess;
            end
         end
         StAccess: stateD = StIdle;
         default:  stateD = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         stateQ      <= StIdle;
         lastWinnerQ <= 1'b1;
         winnerQ     <= 1'b0;
         weQ         <= 1'b0;
         addrQ       <= '0;
         wdataQ      <= '0;
         rdata0Q     <= '0;
         rdata1Q     <= '0;
         rvalid0Q    <= 1'b0;
         rvalid1Q    <= 1'b0;
      end else begin
         stateQ   <= stateD;
         rvalid0Q <= 1'b0;
         rvalid1Q <= 1'b0;
         if (accept) begin
            addrQ       <= winner ? addr1 : addr0;
            wdataQ      <= winner ? wdata1 : wdata0;
            weQ         <= winner ? we1 : we0;
            winnerQ     <= winner;
            lastWinnerQ <= winner;
         end
         // mem_rdata is only trusted during a read access; it may be Z otherwise.
         if (stateQ == StAccess && !weQ) begin
            if (winnerQ) begin
               rdata1Q  <= mem_rdata;
               rvalid1Q <= 1'b1;
            end else begin
               rdata0Q  <= mem_rdata;
               rvalid0Q <= 1'b1;
            end
         end
      end
   end

   // Enables decode from state so reset kills an in-flight access immediately.
   assign busy      = (stateQ == StAccess);
   assign mem_read  = busy & ~weQ;
   assign mem_write = busy & weQ;
   assign mem_addr  = addrQ;
   assign mem_wdata = wdataQ;
   assign rdata0    = rdata0Q;
   assign rdata1    = rdata1Q;
   assign rvalid0   = rvalid0Q;
   assign rvalid1   = rvalid1Q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic aReset, bReset, memInit;

   // DUT A: round-robin
   logic       aReq0, aWe0, aGnt0, aRvalid0, aReq1, aWe1, aGnt1, aRvalid1;
   logic [7:0] aAddr0, aWdata0, aRdata0, aAddr1, aWdata1, aRdata1;
   logic [7:0] aMemAddr, aMemWdata;
   logic       aMemRead, aMemWrite, aBusy;
   wire  [7:0] aMemRdata;
   logic [7:0] memA [256];

   // DUT B: fixed priority
   logic       bReq0, bWe0, bGnt0, bRvalid0, bReq1, bWe1, bGnt1, bRvalid1;
   logic [7:0] bAddr0, bWdata0, bRdata0, bAddr1, bWdata1, bRdata1;
   logic [7:0] bMemAddr, bMemWdata;
   logic       bMemRead, bMemWrite, bBusy;
   wire  [7:0] bMemRdata;
   logic [7:0] memB [256];

   int nVec = 0;
   int nErr = 0;

   data_mem_arbiter #(.FIXED_PRIO(0), .AW(8), .DW(8)) dutA (
      .CLK(CLK), .Reset(aReset),
      .req0(aReq0), .we0(aWe0), .addr0(aAddr0), .wdata0(aWdata0),
      .gnt0(aGnt0), .rvalid0(aRvalid0), .rdata0(aRdata0),
      .req1(aReq1), .we1(aWe1), .addr1(aAddr1), .wdata1(aWdata1),
      .gnt1(aGnt1), .rvalid1(aRvalid1), .rdata1(aRdata1),
      .mem_addr(aMemAddr), .mem_read(aMemRead), .mem_write(aMemWrite),
      .mem_wdata(aMemWdata), .mem_rdata(aMemRdata), .busy(aBusy)
   );

   data_mem_arbiter #(.FIXED_PRIO(1), .AW(8), .DW(8)) dutB (
      .CLK(CLK), .Reset(bReset),
      .req0(bReq0), .we0(bWe0), .addr0(bAddr0), .wdata0(bWdata0),
      .gnt0(bGnt0), .rvalid0(bRvalid0), .rdata0(bRdata0),
      .req1(bReq1), .we1(bWe1), .addr1(bAddr1), .wdata1(bWdata1),
      .gnt1(bGnt1), .rvalid1(bRvalid1), .rdata1(bRdata1),
      .mem_addr(bMemAddr), .mem_read(bMemRead), .mem_write(bMemWrite),
      .mem_wdata(bMemWdata), .mem_rdata(bMemRdata), .busy(bBusy)
   );

   // Memory models: combinational read, Z when not reading, write on the clock edge.
   assign aMemRdata = aMemRead ? memA[aMemAddr] : 8'bz;
   assign bMemRdata = bMemRead ? memB[bMemAddr] : 8'bz;

   always @(posedge CLK) begin
      if (memInit) begin
         for (int i = 0; i < 256; i++) begin
            memA[i] <= 8'(i) ^ 8'h5A;
            memB[i] <= 8'(i) ^ 8'h5A;
         end
         memA[8'h10] <= 8'h77;
         memA[8'h55] <= 8'h11;
         memA[8'hFF] <= 8'hC3;
      end else begin
         if (aMemWrite) memA[aMemAddr] <= aMemWdata;
         if (bMemWrite) memB[bMemAddr] <= bMemWdata;
      end
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      aReset = 1'b1; bReset = 1'b1; memInit = 1'b1;
      {aReq0, aWe0, aReq1, aWe1} = '0;
      {aAddr0, aWdata0, aAddr1, aWdata1} = '0;
      {bReq0, bWe0, bReq1, bWe1} = '0;
      {bAddr0, bWdata0, bAddr1, bWdata1} = '0;
      @(negedge CLK);
      memInit = 1'b0;
      @(negedge CLK);
      #1;
      // ---- reset values
      checkEq("rst_gnt",    {aGnt0, aGnt1}, 0);
      checkEq("rst_rvalid", {aRvalid0, aRvalid1}, 0);
      checkEq("rst_memen",  {aMemRead, aMemWrite}, 0);
      checkEq("rst_busy",   aBusy, 0);
      checkEq("rst_maddr",  aMemAddr, 0);
      checkEq("rst_mwdata", aMemWdata, 0);
      checkEq("rst_rdata",  {aRdata0, aRdata1}, 0);
      aReset = 1'b0; bReset = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         checkEq("idle_memen", {aMemRead, aMemWrite, aBusy}, 0);
      end

      // ---- port 0 write 0x3C = 0xA5, then read it back
      aReq0 = 1; aWe0 = 1; aAddr0 = 8'h3C; aWdata0 = 8'hA5;
      #1;
      checkEq("wr_gnt", {aGnt0, aGnt1}, 2'b10);
      checkEq("wr_idle_memen", {aMemRead, aMemWrite}, 0);
      @(negedge CLK);
      aReq0 = 0;
      checkEq("wr_acc_memen", {aMemRead, aMemWrite, aBusy}, 3'b011);
      checkEq("wr_acc_addr", aMemAddr, 8'h3C);
      checkEq("wr_acc_wdata", aMemWdata, 8'hA5);
      checkEq("wr_acc_gnt", {aGnt0, aGnt1}, 0);
      @(negedge CLK);
      checkEq("wr_after_memen", {aMemRead, aMemWrite}, 0);
      checkEq("wr_no_rvalid", {aRvalid0, aRvalid1}, 0);
      checkEq("wr_hold_addr", aMemAddr, 8'h3C);
      checkEq("wr_mem", memA[8'h3C], 8'hA5);
      aReq0 = 1; aWe0 = 0; aAddr0 = 8'h3C;
      #1;
      checkEq("rd_gnt", {aGnt0, aGnt1}, 2'b10);
      @(negedge CLK);
      aReq0 = 0;
      checkEq("rd_acc_memen", {aMemRead, aMemWrite}, 2'b10);
      checkEq("rd_acc_rvalid", aRvalid0, 0);
      @(negedge CLK);
      checkEq("rd_rvalid", {aRvalid0, aRvalid1}, 2'b10);
      checkEq("rd_rdata0", aRdata0, 8'hA5);
      checkEq("rd_rdata1_hold", aRdata1, 8'h00);
      @(negedge CLK);
      checkEq("rd_rvalid_pulse", aRvalid0, 0);
      checkEq("rd_rdata0_hold", aRdata0, 8'hA5);

      // ---- port 1 back-to-back reads 0xFF then 0x00
      aReq1 = 1; aWe1 = 0; aAddr1 = 8'hFF;
      #1;
      checkEq("b2b_gnt1", {aGnt0, aGnt1}, 2'b01);
      @(negedge CLK);
      aAddr1 = 8'h00;
      #1;
      checkEq("b2b_acc1_addr", aMemAddr, 8'hFF);
      checkEq("b2b_acc1_gnt", {aGnt0, aGnt1}, 0);
      @(negedge CLK);
      #1;
      checkEq("b2b_gnt2", {aGnt0, aGnt1}, 2'b01);
      checkEq("b2b_rvalid1", aRvalid1, 1);
      checkEq("b2b_rdata1_ff", aRdata1, 8'hC3);
      @(negedge CLK);
      aReq1 = 0;
      checkEq("b2b_acc2_addr", aMemAddr, 8'h00);
      @(negedge CLK);
      checkEq("b2b_rvalid2", aRvalid1, 1);
      checkEq("b2b_rdata1_00", aRdata1, 8'h5A);
      checkEq("b2b_rdata0_hold", aRdata0, 8'hA5);

      // ---- round-robin, both ports held for 8 grants
      aReq0 = 1; aWe0 = 0; aAddr0 = 8'h3C;
      aReq1 = 1; aWe1 = 0; aAddr1 = 8'h10;
      for (int i = 0; i < 8; i++) begin
         #1;
         checkEq($sformatf("rr_gnt%0d", i), {aGnt0, aGnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
         if (i > 0 && i % 2 == 0) begin
            checkEq("rr_rvalid1", {aRvalid0, aRvalid1}, 2'b01);
            checkEq("rr_rdata1", aRdata1, 8'h77);
         end
         if (i % 2 == 1) begin
            checkEq("rr_rvalid0", {aRvalid0, aRvalid1}, 2'b10);
            checkEq("rr_rdata0", aRdata0, 8'hA5);
         end
         @(negedge CLK);
         if (i == 7) begin
            aReq0 = 0; aReq1 = 0;
         end
         @(negedge CLK);
      end
      checkEq("rr_last_rvalid1", aRvalid1, 1);
      checkEq("rr_last_rdata1", aRdata1, 8'h77);

      // ---- reset during ACCESS of a write to 0x55 (old 0x11)
      aReq0 = 1; aWe0 = 1; aAddr0 = 8'h55; aWdata0 = 8'h22;
      #1;
      checkEq("rstacc_gnt", {aGnt0, aGnt1}, 2'b10);
      @(negedge CLK);
      aReq0 = 0;
      checkEq("rstacc_memwrite", aMemWrite, 1);
      aReset = 1;
      #1;
      checkEq("rstacc_drop", {aMemRead, aMemWrite, aBusy}, 0);
      checkEq("rstacc_addr", aMemAddr, 0);
      @(negedge CLK);
      aReset = 0;
      checkEq("rstacc_mem", memA[8'h55], 8'h11);
      checkEq("rstacc_rvalid", {aRvalid0, aRvalid1}, 0);
      aReq0 = 1; aWe0 = 0; aAddr0 = 8'h55;
      aReq1 = 1; aWe1 = 0; aAddr1 = 8'h10;
      #1;
      checkEq("rstacc_tie", {aGnt0, aGnt1}, 2'b10);
      @(negedge CLK);
      aReq0 = 0; aReq1 = 0;
      @(negedge CLK);
      checkEq("rstacc_rd_rvalid", {aRvalid0, aRvalid1}, 2'b10);
      checkEq("rstacc_rd_data", aRdata0, 8'h11);

      // ---- fixed priority: port 0 wins every tie until it drops
      bReq0 = 1; bWe0 = 0; bAddr0 = 8'h20;
      bReq1 = 1; bWe1 = 0; bAddr1 = 8'h21;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkEq($sformatf("fp_gnt%0d", i), {bGnt0, bGnt1}, 2'b10);
         @(negedge CLK);
         if (i == 2) bReq0 = 0;
         @(negedge CLK);
      end
      #1;
      checkEq("fp_gnt1", {bGnt0, bGnt1}, 2'b01);
      checkEq("fp_rvalid0", bRvalid0, 1);
      checkEq("fp_rdata0", bRdata0, 8'h7A);
      @(negedge CLK);
      bReq1 = 0;
      @(negedge CLK);
      checkEq("fp_rvalid1", {bRvalid0, bRvalid1}, 2'b01);
      checkEq("fp_rdata1", bRdata1, 8'h7B);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
